// File: rtl/time_set_ctrl.sv
// time_set_ctrl: front-panel mode/setting controller for the digital clock.
// Synchronises and debounces the mode/hour/minute buttons, sequences the
// RUN_HM -> RUN_MS -> SET_HOUR -> SET_MIN mode ring, issues run-enable and
// increment/clear pulses to the time counters, and selects the BCD word and
// blink mask for the 4-digit display.
// Optional feature: define AUTO_REPEAT_EN to auto-repeat held hour/min buttons.
module time_set_ctrl #(
  parameter int DEB_CNT    = 999_999,
  parameter int BLINK_CNT  = 24_999_999,
  parameter int TIMEOUT_S  = 10,
  parameter int REPEAT_DLY = 49_999_999,
  parameter int REPEAT_PER = 19_999_999
) (
  input  logic        sys_clk,
  input  logic        sys_rst_p,
  input  logic        btn_mode,
  input  logic        btn_hour,
  input  logic        btn_min,
  input  logic        tick_1hz,
  input  logic [7:0]  hour,
  input  logic [7:0]  min,
  input  logic [7:0]  sec,
  output logic        run_en,
  output logic        inc_hour,
  output logic        inc_min,
  output logic        clr_sec,
  output logic [15:0] disp_data,
  output logic [3:0]  blank,
  output logic [1:0]  mode
);

  typedef enum logic [1:0] {
    RUN_HM   = 2'd0,
    RUN_MS   = 2'd1,
    SET_HOUR = 2'd2,
    SET_MIN  = 2'd3
  } state_t;

  localparam int DEB_W = (DEB_CNT > 0) ? $clog2(DEB_CNT + 1) : 1;
  localparam int BLK_W = (BLINK_CNT > 0) ? $clog2(BLINK_CNT + 1) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_S + 1);

  // button index: 0 = mode, 1 = hour, 2 = minute
  logic [2:0]       r_sync1, r_sync2, r_deb_lvl, r_deb_prev;
  logic [DEB_W-1:0] r_deb_cnt [0:2];
  logic [2:0]       w_press;
  state_t           r_state, w_next;
  logic             w_clr;
  logic             r_run_en, r_inc_hour, r_inc_min, r_clr_sec;
  logic [BLK_W-1:0] r_blk_cnt;
  logic             r_phase;
  logic [TO_W-1:0]  r_to_cnt;
  logic             w_rep, w_hour_acc, w_min_acc, w_any_press, w_in_set;
  logic             w_to_fire, w_set_entry;
  logic [15:0]      w_disp;
  logic [3:0]       w_blank;

  // two-flop synchroniser for the three asynchronous buttons
  always_ff @(posedge sys_clk or posedge sys_rst_p) begin
    if (sys_rst_p) begin
      r_sync1 <= 3'b000;
      r_sync2 <= 3'b000;
    end else begin
      r_sync1 <= {btn_min, btn_hour, btn_mode};
      r_sync2 <= r_sync1;
    end
  end

  // debounce: a level must differ for DEB_CNT+1 straight cycles to be taken
  always_ff @(posedge sys_clk or posedge sys_rst_p) begin
    if (sys_rst_p) begin
      for (int i = 0; i < 3; i++) r_deb_cnt[i] <= {DEB_W{1'b0}};
      r_deb_lvl  <= 3'b000;
      r_deb_prev <= 3'b000;
    end else begin
      r_deb_prev <= r_deb_lvl;
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] != r_deb_lvl[i]) begin
          if (r_deb_cnt[i] == DEB_W'(DEB_CNT)) begin
            r_deb_lvl[i] <= r_sync2[i];
            r_deb_cnt[i] <= {DEB_W{1'b0}};
          end else begin
            r_deb_cnt[i] <= r_deb_cnt[i] + DEB_W'(1);
          end
        end else begin
          r_deb_cnt[i] <= {DEB_W{1'b0}};
        end
      end
    end
  end

  // press events are rising edges of the debounced level only
  assign w_press    = r_deb_lvl & ~r_deb_prev;
  assign w_in_set   = (r_state == SET_HOUR) || (r_state == SET_MIN);
  // a simultaneous mode press always wins over an increment
  assign w_hour_acc = (r_state == SET_HOUR) & (w_press[1] | w_rep) & ~w_press[0];
  assign w_min_acc  = (r_state == SET_MIN) & (w_press[2] | w_rep) & ~w_press[0];
  assign w_any_press = (|w_press) | w_rep;
  // a press in the same cycle as the last tick keeps the set state alive
  assign w_to_fire  = w_in_set & tick_1hz & ~w_any_press & (r_to_cnt == TO_W'(TIMEOUT_S - 1));

`ifdef AUTO_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_DLY + 1);
  logic [REP_W-1:0] r_rep_cnt;
  logic             r_rep_act;
  logic             w_rep_hold, w_rep_start;

  assign w_rep_hold  = ((r_state == SET_HOUR) & r_deb_lvl[1]) | ((r_state == SET_MIN) & r_deb_lvl[2]);
  assign w_rep_start = ~w_press[0] & (((r_state == SET_HOUR) & w_press[1]) | ((r_state == SET_MIN) & w_press[2]));
  assign w_rep       = r_rep_act & w_rep_hold & ~w_press[0] & (r_rep_cnt == REP_W'(REPEAT_DLY - 1));

  // hold timer: counts cycles since the press, reloads so repeats land every REPEAT_PER
  always_ff @(posedge sys_clk or posedge sys_rst_p) begin
    if (sys_rst_p) begin
      r_rep_act <= 1'b0;
      r_rep_cnt <= {REP_W{1'b0}};
    end else if (w_rep_start) begin
      r_rep_act <= 1'b1;
      r_rep_cnt <= REP_W'(1);
    end else if (r_rep_act & w_rep_hold & ~w_press[0]) begin
      r_rep_act <= 1'b1;
      if (w_rep) begin
        r_rep_cnt <= REP_W'(REPEAT_DLY - REPEAT_PER);
      end else begin
        r_rep_cnt <= r_rep_cnt + REP_W'(1);
      end
    end else begin
      r_rep_act <= 1'b0;
      r_rep_cnt <= {REP_W{1'b0}};
    end
  end
`else
  logic w_unused_rep;
  assign w_rep        = 1'b0;
  assign w_unused_rep = (REPEAT_DLY > REPEAT_PER);
`endif

  // mode state register
  always_ff @(posedge sys_clk or posedge sys_rst_p) begin
    if (sys_rst_p) begin
      r_state <= RUN_HM;
    end else begin
      r_state <= w_next;
    end
  end

  // next-state decode; leaving SET_MIN or timing out requests a seconds clear
  always_comb begin
    w_next = r_state;
    w_clr  = 1'b0;
    case (r_state)
      RUN_HM: begin
        if (w_press[0]) w_next = RUN_MS;
        else            w_next = RUN_HM;
      end
      RUN_MS: begin
        if (w_press[0]) w_next = SET_HOUR;
        else            w_next = RUN_MS;
      end
      SET_HOUR: begin
        if (w_press[0]) begin
          w_next = SET_MIN;
        end else if (w_to_fire) begin
          w_next = RUN_HM;
          w_clr  = 1'b1;
        end else begin
          w_next = SET_HOUR;
        end
      end
      SET_MIN: begin
        if (w_press[0] || w_to_fire) begin
          w_next = RUN_HM;
          w_clr  = 1'b1;
        end else begin
          w_next = SET_MIN;
        end
      end
      default: begin
        w_next = RUN_HM;
        w_clr  = 1'b0;
      end
    endcase
  end

  // registered control outputs, aligned with the state they belong to
  always_ff @(posedge sys_clk or posedge sys_rst_p) begin
    if (sys_rst_p) begin
      r_run_en   <= 1'b1;
      r_inc_hour <= 1'b0;
      r_inc_min  <= 1'b0;
      r_clr_sec  <= 1'b0;
    end else begin
      r_run_en   <= (w_next == RUN_HM) || (w_next == RUN_MS);
      r_inc_hour <= w_hour_acc;
      r_inc_min  <= w_min_acc;
      r_clr_sec  <= w_clr;
    end
  end

  assign w_set_entry = ((w_next == SET_HOUR) || (w_next == SET_MIN)) && (w_next != r_state);

  // blink timer; restarts on set entry and on each increment so the field shows at once
  always_ff @(posedge sys_clk or posedge sys_rst_p) begin
    if (sys_rst_p) begin
      r_blk_cnt <= {BLK_W{1'b0}};
      r_phase   <= 1'b0;
    end else if (w_set_entry | w_hour_acc | w_min_acc) begin
      r_blk_cnt <= {BLK_W{1'b0}};
      r_phase   <= 1'b0;
    end else if (r_blk_cnt == BLK_W'(BLINK_CNT)) begin
      r_blk_cnt <= {BLK_W{1'b0}};
      r_phase   <= ~r_phase;
    end else begin
      r_blk_cnt <= r_blk_cnt + BLK_W'(1);
    end
  end

  // inactivity timer: counts seconds in set states, any press restarts it
  always_ff @(posedge sys_clk or posedge sys_rst_p) begin
    if (sys_rst_p) begin
      r_to_cnt <= {TO_W{1'b0}};
    end else if (!w_in_set || w_any_press || w_to_fire) begin
      r_to_cnt <= {TO_W{1'b0}};
    end else if (tick_1hz) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end else begin
      r_to_cnt <= r_to_cnt;
    end
  end

  // display word and blink mask selected by the current mode
  always_comb begin
    w_disp  = {hour, min};
    w_blank = 4'b0000;
    case (r_state)
      RUN_HM:   w_disp = {hour, min};
      RUN_MS:   w_disp = {min, sec};
      SET_HOUR: w_blank = {r_phase, r_phase, 2'b00};
      SET_MIN:  w_blank = {2'b00, r_phase, r_phase};
      default: begin
        w_disp  = {hour, min};
        w_blank = 4'b0000;
      end
    endcase
  end

  assign run_en    = r_run_en;
  assign inc_hour  = r_inc_hour;
  assign inc_min   = r_inc_min;
  assign clr_sec   = r_clr_sec;
  assign disp_data = w_disp;
  assign blank     = w_blank;
  assign mode      = r_state;

endmodule
